a2d_intf: RTL and testbench

//  SPI master and round-robin conversion sequencer for the 8-channel 12-bit load-cell/pot/battery ADC.

---
 rtl/a2d_intf.sv | 157 +++++++++++++++
 tb/tb_a2d_intf.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_intf.sv
// SPI master and round-robin conversion sequencer for the 8-channel 12-bit ADC.
// Each nxt in IDLE runs CMD, GAP, READ, DONE on the next channel and pulses vld when its register updates.
module a2d_intf #(
  parameter int SCLK_DIV = 32,
  parameter int CH_LFT   = 0,
  parameter int CH_RGHT  = 4,
  parameter int CH_STEER = 5,
  parameter int CH_BATT  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        busy,
  output logic        vld,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int SW   = $clog2(HALF);
  localparam logic [SW-1:0] SUB_LAST = SW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [5:0]    hp_q, hp_d;
  logic [1:0]    rr_q, rr_d;
  logic          sclk_q, sclk_d;
  logic          ss_n_q, ss_n_d;
  logic          mosi_q, mosi_d;
  logic          vld_q, vld_d;
  logic [11:0]   rx_q, rx_d;
  logic [11:0]   lft_q, lft_d, rght_q, rght_d, steer_q, steer_d, batt_q, batt_d;

  logic [2:0]    ch;
  logic [15:0]   cmd;
  logic [5:0]    hp_last;
  logic          half_end, seg_end, in_txn_d;

  always_comb begin
    case (rr_q)
      2'd0:    ch = 3'(CH_LFT);
      2'd1:    ch = 3'(CH_RGHT);
      2'd2:    ch = 3'(CH_STEER);
      default: ch = 3'(CH_BATT);
    endcase
    cmd = {2'b00, ch, 11'h000};
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    hp_d    = hp_q;
    rr_d    = rr_q;
    rx_d    = rx_q;
    mosi_d  = mosi_q;
    vld_d   = 1'b0;
    lft_d   = lft_q;
    rght_d  = rght_q;
    steer_d = steer_q;
    batt_d  = batt_q;

    // Time is kept in half SCLK periods: a transaction is 34 of them, the gap is 2.
    hp_last  = (state_q == GAP) ? 6'd1 : 6'd33;
    half_end = (sub_q == SUB_LAST);
    seg_end  = half_end && (hp_q == hp_last);

    if (state_q == CMD || state_q == GAP || state_q == READ) begin
      if (half_end) begin
        sub_d = '0;
        hp_d  = (hp_q == hp_last) ? 6'd0 : hp_q + 6'd1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: if (nxt) begin
        state_d = CMD;
        sub_d   = '0;
        hp_d    = 6'd0;
      end
      CMD:  if (seg_end) state_d = GAP;
      GAP:  if (seg_end) state_d = READ;
      READ: if (seg_end) begin
        state_d = DONE;
        vld_d   = 1'b1;
        rr_d    = rr_q + 2'd1;
        case (rr_q)
          2'd0:    lft_d   = rx_q;
          2'd1:    rght_d  = rx_q;
          2'd2:    steer_d = rx_q;
          default: batt_d  = rx_q;
        endcase
      end
      default: state_d = IDLE;
    endcase

    // SCLK is low in odd half periods 1..31 of a transaction, high otherwise.
    in_txn_d = (state_d == CMD) || (state_d == READ);
    sclk_d   = !(in_txn_d && hp_d[0] && (hp_d < 6'd32));
    ss_n_d   = !in_txn_d;

    if (sclk_q && !sclk_d) mosi_d = cmd[4'd15 - hp_d[4:1]];
    if (!sclk_q && sclk_d) rx_d = {rx_q[10:0], MISO};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sub_q   <= '0;
      hp_q    <= 6'd0;
      rr_q    <= 2'd0;
      sclk_q  <= 1'b1;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      vld_q   <= 1'b0;
      rx_q    <= 12'h000;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      steer_q <= 12'h000;
      batt_q  <= 12'h000;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      hp_q    <= hp_d;
      rr_q    <= rr_d;
      sclk_q  <= sclk_d;
      ss_n_q  <= ss_n_d;
      mosi_q  <= mosi_d;
      vld_q   <= vld_d;
      rx_q    <= rx_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      steer_q <= steer_d;
      batt_q  <= batt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign vld       = vld_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign SS_n      = ss_n_q;
  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: behavioural ADC slave, SPI timing monitor and a scoreboard of
// expected command words and result registers filled as each conversion is launched.
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst, nxt, MISO;
  logic        busy, vld, SS_n, SCLK, MOSI;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  a2d_intf dut (
    .clk(clk), .rst(rst), .nxt(nxt), .busy(busy), .vld(vld),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // ADC slave: returns the channel addressed by the previous command word.
  logic [11:0] adc_val [8];
  logic [15:0] rx_sh, resp;
  int          idx, last_ch;
  logic [15:0] obs_cmd [$];

  initial last_ch = 0;
  always @(negedge SS_n) begin
    idx   = 15;
    rx_sh = 16'h0;
    resp  = {4'h9, adc_val[last_ch]};
  end
  always @(negedge SCLK) if (SS_n === 1'b0 && idx >= 0) begin
    MISO = resp[idx];
    idx--;
  end
  always @(posedge SCLK) if (SS_n === 1'b0) rx_sh = {rx_sh[14:0], MOSI};
  always @(posedge SS_n) begin
    obs_cmd.push_back(rx_sh);
    last_ch = int'(rx_sh[13:11]);
  end

  // SPI timing monitor, sampled mid-cycle.
  logic sclk_p = 1'b1, ss_p = 1'b1;
  int   since_fall = 0, nfall = 0, pmin = 9999, pmax = 0, hi_cnt = 0;
  int   obs_falls [$], obs_pmin [$], obs_pmax [$], obs_gap [$];
  always @(negedge clk) begin
    if (SS_n === 1'b0 && sclk_p === 1'b1 && SCLK === 1'b0) begin
      if (nfall > 0) begin
        if (since_fall < pmin) pmin = since_fall;
        if (since_fall > pmax) pmax = since_fall;
      end
      nfall++;
      since_fall = 0;
    end
    since_fall++;
    if (ss_p === 1'b0 && SS_n === 1'b1) begin
      obs_falls.push_back(nfall);
      obs_pmin.push_back(pmin);
      obs_pmax.push_back(pmax);
      nfall = 0; pmin = 9999; pmax = 0;
    end
    if (ss_p === 1'b1 && SS_n === 1'b0 && hi_cnt > 0) obs_gap.push_back(hi_cnt);
    if (busy !== 1'b1) hi_cnt = 0;
    else if (SS_n === 1'b1) hi_cnt++;
    sclk_p = SCLK;
    ss_p   = SS_n;
  end

  // Scoreboard model.
  logic [2:0]  ch_tab [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
  logic [11:0] exp_regs [4];
  int          rr_m = 0;
  logic [15:0] exp_cmd [$];
  int          exp_reg [$];
  logic [11:0] exp_val [$];

  task automatic clear_model();
    rr_m = 0;
    for (int i = 0; i < 4; i++) exp_regs[i] = 12'h000;
    exp_cmd.delete(); exp_reg.delete(); exp_val.delete(); obs_cmd.delete();
  endtask

  // Launches one conversion; optional extra nxt pulses and a reset at given relative cycles.
  task automatic run_conv(input int pa, input int pb, input int ra,
                          output int vld_at, output int nvld, output int busy_low,
                          output logic [47:0] snap, output logic [2:0] at_rst);
    int e0, rel;
    logic [2:0] c;
    if (ra < 0) begin
      c = ch_tab[rr_m];
      exp_cmd.push_back({2'b00, c, 11'h000});
      exp_cmd.push_back({2'b00, c, 11'h000});
      exp_reg.push_back(rr_m);
      exp_val.push_back(adc_val[c]);
      rr_m = (rr_m + 1) % 4;
    end
    vld_at = -1; nvld = 0; busy_low = -1; snap = '0; at_rst = 3'b000;
    @(negedge clk) nxt = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    nxt = 1'b0;
    for (int k = 0; k < 1250; k++) begin
      @(negedge clk);
      rel = cyc - e0 + 1;
      nxt = (rel == pa) || (rel == pb);
      rst = (rel == ra);
      if (vld === 1'b1) begin
        nvld++;
        if (vld_at < 0) vld_at = rel;
        snap = {batt, steer_pot, rght_ld, lft_ld};
      end
      if (busy === 1'b0 && busy_low < 0) busy_low = rel;
      if (rel == ra + 1) at_rst = {SS_n, SCLK, busy};
    end
    nxt = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; nxt = 1'b0; MISO = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (SS_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n: got %b want 1", SS_n); end
    n_chk++; if (SCLK !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b want 1", SCLK); end
    n_chk++; if (MOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", vld); end
    n_chk++;
    if ({batt, steer_pot, rght_ld, lft_ld} !== 48'h0) begin
      n_fail++; $display("FAIL reset_regs: got %h want 0", {batt, steer_pot, rght_ld, lft_ld});
    end
    rst = 1'b0;
    @(negedge clk);
    clear_model();
  endtask

  task automatic test_single();
    int vat, nv, bl, r;
    logic [47:0] snap, want;
    logic [2:0] ar;
    logic [15:0] got, exp;
    adc_val[0] = 12'hABC;
    run_conv(-1, -1, -1, vat, nv, bl, snap, ar);
    n_chk++; if (vat !== 1121) begin n_fail++; $display("FAIL single_vld_cycle: got %0d want 1121", vat); end
    n_chk++; if (nv !== 1) begin n_fail++; $display("FAIL single_vld_count: got %0d want 1", nv); end
    n_chk++; if (bl !== 1122) begin n_fail++; $display("FAIL single_busy_low: got %0d want 1122", bl); end
    r = exp_reg.pop_front();
    exp_regs[r] = exp_val.pop_front();
    want = {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
    n_chk++; if (snap !== want) begin n_fail++; $display("FAIL single_regs: got %h want %h", snap, want); end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (obs_cmd.size() == 0) begin n_fail++; $display("FAIL single_cmd: no word got, want %h", exp_cmd[0]); end
      else begin
        got = obs_cmd.pop_front(); exp = exp_cmd.pop_front();
        if (got !== exp) begin n_fail++; $display("FAIL single_cmd: got %h want %h", got, exp); end
      end
    end
  endtask

  task automatic test_round_robin();
    int vat, nv, bl, r;
    logic [47:0] snap, want;
    logic [2:0] ar;
    logic [15:0] got, exp;
    adc_val[4] = 12'h123; adc_val[5] = 12'h456; adc_val[6] = 12'hFFF; adc_val[0] = 12'h3C7;
    for (int n = 0; n < 4; n++) begin
      run_conv(-1, -1, -1, vat, nv, bl, snap, ar);
      r = exp_reg.pop_front();
      exp_regs[r] = exp_val.pop_front();
      want = {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
      n_chk++; if (nv !== 1 || snap !== want) begin
        n_fail++; $display("FAIL rr_regs[%0d]: got %h (vld %0d) want %h (vld 1)", n, snap, nv, want);
      end
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs_cmd.size() == 0) begin n_fail++; $display("FAIL rr_cmd[%0d]: no word got, want %h", n, exp_cmd[0]); end
        else begin
          got = obs_cmd.pop_front(); exp = exp_cmd.pop_front();
          if (got !== exp) begin n_fail++; $display("FAIL rr_cmd[%0d]: got %h want %h", n, got, exp); end
        end
      end
    end
  endtask

  task automatic test_ignore_nxt();
    int vat, nv, bl, r;
    logic [47:0] snap, want;
    logic [2:0] ar;
    logic [15:0] got, exp;
    adc_val[4] = 12'h7E1; adc_val[5] = 12'h0F0;
    for (int n = 0; n < 2; n++) begin
      if (n == 0) run_conv(10, 600, -1, vat, nv, bl, snap, ar);
      else        run_conv(-1, -1, -1, vat, nv, bl, snap, ar);
      n_chk++; if (nv !== 1 || bl !== 1122) begin
        n_fail++; $display("FAIL ignore_vld[%0d]: got vld %0d busy_low %0d want 1 and 1122", n, nv, bl);
      end
      r = exp_reg.pop_front();
      exp_regs[r] = exp_val.pop_front();
      want = {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
      n_chk++; if (snap !== want) begin n_fail++; $display("FAIL ignore_regs[%0d]: got %h want %h", n, snap, want); end
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs_cmd.size() == 0) begin n_fail++; $display("FAIL ignore_cmd[%0d]: no word got, want %h", n, exp_cmd[0]); end
        else begin
          got = obs_cmd.pop_front(); exp = exp_cmd.pop_front();
          if (got !== exp) begin n_fail++; $display("FAIL ignore_cmd[%0d]: got %h want %h", n, got, exp); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int vat, nv, bl, r;
    logic [47:0] snap, want;
    logic [2:0] ar;
    logic [15:0] got, exp;
    run_conv(-1, -1, 700, vat, nv, bl, snap, ar);
    n_chk++; if (ar !== 3'b110) begin n_fail++; $display("FAIL rstmid_pins: got {ss,sclk,busy}=%b want 110", ar); end
    n_chk++; if (nv !== 0) begin n_fail++; $display("FAIL rstmid_vld: got %0d want 0", nv); end
    n_chk++;
    if ({batt, steer_pot, rght_ld, lft_ld} !== 48'h0) begin
      n_fail++; $display("FAIL rstmid_regs: got %h want 0", {batt, steer_pot, rght_ld, lft_ld});
    end
    clear_model();
    adc_val[0] = 12'h5A5;
    run_conv(-1, -1, -1, vat, nv, bl, snap, ar);
    r = exp_reg.pop_front();
    exp_regs[r] = exp_val.pop_front();
    want = {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
    n_chk++; if (nv !== 1 || snap !== want) begin
      n_fail++; $display("FAIL rstmid_conv: got %h (vld %0d) want %h (vld 1)", snap, nv, want);
    end
    n_chk++;
    if (obs_cmd.size() == 0) begin n_fail++; $display("FAIL rstmid_cmd: no word got, want %h", exp_cmd[0]); end
    else begin
      got = obs_cmd.pop_front(); exp = exp_cmd.pop_front();
      if (got !== exp) begin n_fail++; $display("FAIL rstmid_cmd: got %h want %h", got, exp); end
    end
    obs_cmd.delete(); exp_cmd.delete();
  endtask

  task automatic test_spi_timing();
    int vat, nv, bl, f, lo, hi;
    logic [47:0] snap;
    logic [2:0] ar;
    obs_falls.delete(); obs_pmin.delete(); obs_pmax.delete(); obs_gap.delete();
    run_conv(-1, -1, -1, vat, nv, bl, snap, ar);
    void'(exp_reg.pop_front()); void'(exp_val.pop_front());
    obs_cmd.delete(); exp_cmd.delete();
    for (int t = 0; t < 2; t++) begin
      n_chk++;
      if (obs_falls.size() == 0) begin n_fail++; $display("FAIL spi_txn[%0d]: no transaction got, want 16 falls", t); end
      else begin
        f = obs_falls.pop_front(); lo = obs_pmin.pop_front(); hi = obs_pmax.pop_front();
        if (f !== 16 || lo !== 32 || hi !== 32) begin
          n_fail++; $display("FAIL spi_txn[%0d]: got falls %0d period %0d..%0d want 16 and 32..32", t, f, lo, hi);
        end
      end
    end
    n_chk++;
    if (obs_gap.size() != 1) begin n_fail++; $display("FAIL spi_gap: got %0d gaps want 1", obs_gap.size()); end
    else if (obs_gap[0] !== 32) begin n_fail++; $display("FAIL spi_gap: got %0d cycles want 32", obs_gap[0]); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) adc_val[i] = 12'(i * 16'h111);
    test_reset();
    test_single();
    test_round_robin();
    test_ignore_nxt();
    test_reset_mid();
    test_spi_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
